// File: rtl/mag_decimator_pkg.sv
// Shared constants and helpers for the magnitude decimator.
// Output width matches the host averager input.
package mag_decimator_pkg;

    localparam int OW = 24;
    localparam int CW = 8;

    typedef logic [OW-1:0] out_t;
    typedef logic [CW-1:0] cnt_t;

    localparam out_t OUT_MAX = '1;

    function automatic cnt_t eff_len(input cnt_t d);
        return (d == '0) ? cnt_t'(1) : d;
    endfunction

endpackage

// File: rtl/mag_decimator_if.sv
// Sample-in / block-result-out bundle for the magnitude decimator.
// The master drives samples and consumes the block results.
interface mag_decimator_if
    import mag_decimator_pkg::*;
#(
    parameter int DW = 16
);

    logic                 en;
    cnt_t                 dec_len;
    logic signed [DW-1:0] adc;
    logic                 adc_s;
    out_t                 data_out;
    logic                 data_s;
    logic                 clip;

    modport master (
        output en,
        output dec_len,
        output adc,
        output adc_s,
        input  data_out,
        input  data_s,
        input  clip
    );

    modport slave (
        input  en,
        input  dec_len,
        input  adc,
        input  adc_s,
        output data_out,
        output data_s,
        output clip
    );

endinterface

// File: rtl/mag_decimator_abs_sat.sv
// Registered signed-to-magnitude stage with most-negative clamp
// and full-scale detect.
module mag_decimator_abs_sat #(
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic signed [DW-1:0] adc,
    input  logic                 adc_s,
    output logic                 v,
    output logic [DW-2:0]        mag,
    output logic                 full
);

    localparam int MW = DW - 1;

    logic          is_min;
    logic          is_max;
    logic [MW-1:0] mag_d;

    always_comb begin
        is_min = adc[DW-1] & ~|adc[DW-2:0];
        is_max = ~adc[DW-1] & &adc[DW-2:0];
        mag_d  = adc[DW-2:0];
        // -2^(DW-1) has no positive twin, so pin it to the largest magnitude
        if (is_min)
            mag_d = '1;
        else if (adc[DW-1])
            mag_d = ~adc[DW-2:0] + MW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v    <= 1'b0;
            mag  <= '0;
            full <= 1'b0;
        end else begin
            v    <= adc_s & en;
            mag  <= mag_d;
            full <= is_min | is_max;
        end
    end

endmodule

// File: rtl/mag_decimator.sv
// Box-car sum of |x| over a programmable block length, one
// saturated 24-bit result per block with a clip flag.
module mag_decimator
    import mag_decimator_pkg::*;
#(
    parameter int DW    = 16,
    parameter int SHIFT = 0
) (
    input  logic          clk,
    input  logic          rst,
    mag_decimator_if.slave bus
);

    localparam int MW = DW - 1;
    localparam int AW = MW + CW;

    logic          v1;
    logic          en1;
    logic [MW-1:0] mag;
    logic          full;

    cnt_t          cnt;
    cnt_t          len_q;
    cnt_t          len_cur;
    logic [AW-1:0] acc;
    logic [AW-1:0] sum;
    logic          sticky;
    logic          sticky_nxt;
    logic          last;
    logic [31:0]   shifted;
    out_t          sat;

    out_t          out_q;
    logic          out_s;
    logic          clip_q;

    mag_decimator_abs_sat #(
        .DW(DW)
    ) u_abs (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.en),
        .adc  (bus.adc),
        .adc_s(bus.adc_s),
        .v    (v1),
        .mag  (mag),
        .full (full)
    );

    // en delayed to line up with the stage-1 valid
    always_ff @(posedge clk) begin
        if (rst)
            en1 <= 1'b0;
        else
            en1 <= bus.en;
    end

    always_comb begin
        len_cur    = (cnt == '0) ? eff_len(bus.dec_len) : len_q;
        sum        = acc + AW'(mag);
        sticky_nxt = sticky | full;
        last       = v1 && (cnt + cnt_t'(1) == len_cur);
        shifted    = 32'(sum >> SHIFT);
        sat        = (shifted > 32'(OUT_MAX)) ? OUT_MAX : shifted[OW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            len_q  <= '0;
            acc    <= '0;
            sticky <= 1'b0;
            out_q  <= '0;
            out_s  <= 1'b0;
            clip_q <= 1'b0;
        end else begin
            out_s <= 1'b0;
            if (v1) begin
                if (last) begin
                    cnt    <= '0;
                    acc    <= '0;
                    sticky <= 1'b0;
                    out_q  <= sat;
                    out_s  <= 1'b1;
                    clip_q <= sticky_nxt;
                end else begin
                    cnt    <= cnt + cnt_t'(1);
                    acc    <= sum;
                    sticky <= sticky_nxt;
                    if (cnt == '0)
                        len_q <= len_cur;
                end
            end else if (!en1) begin
                // en dropped: abandon the partial block
                cnt    <= '0;
                acc    <= '0;
                sticky <= 1'b0;
            end
        end
    end

    assign bus.data_out = out_q;
    assign bus.data_s   = out_s;
    assign bus.clip     = clip_q;

endmodule

// File: tb/tb_mag_decimator.sv
// Directed bench for mag_decimator: DW=16 and DW=18 instances,
// results captured per data_s and checked against hand values.
module tb_mag_decimator;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mag_decimator_if #(.DW(16)) b16 ();
    mag_decimator_if #(.DW(18)) b18 ();

    mag_decimator #(.DW(16), .SHIFT(0)) u16 (
        .clk(clk),
        .rst(rst),
        .bus(b16)
    );

    mag_decimator #(.DW(18), .SHIFT(0)) u18 (
        .clk(clk),
        .rst(rst),
        .bus(b18)
    );

    typedef struct {
        int c;
        int d;
        bit cl;
    } ev_t;

    ev_t q16[$];
    ev_t q18[$];

    int cyc    = 0;
    int total  = 0;
    int passed = 0;
    int st     = 0;
    int s0     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (b16.data_s === 1'b1)
            q16.push_back('{c: cyc, d: int'(b16.data_out), cl: b16.clip});
        if (b18.data_s === 1'b1)
            q18.push_back('{c: cyc, d: int'(b18.data_out), cl: b18.clip});
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic drv(input bit s, input int v16, input int v18);
        @(negedge clk);
        b16.adc_s = s;
        b16.adc   = 16'(v16);
        b18.adc_s = s;
        b18.adc   = 18'(v18);
        if (s) st = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) drv(1'b0, 0, 0);
    endtask

    initial begin
        rst         = 1'b1;
        b16.en      = 1'b0;
        b16.dec_len = 8'd4;
        b16.adc     = '0;
        b16.adc_s   = 1'b0;
        b18.en      = 1'b0;
        b18.dec_len = 8'd0;
        b18.adc     = '0;
        b18.adc_s   = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_data_out", 32'(b16.data_out), 0);
        chk("rst_data_s", 32'(b16.data_s), 0);
        chk("rst_clip", 32'(b16.clip), 0);
        chk("rst_data_out18", 32'(b18.data_out), 0);
        rst    = 1'b0;
        b16.en = 1'b1;

        // constant +1000, block of 4, continuous strobe
        q16.delete();
        for (int i = 0; i < 8; i++) begin
            drv(1'b1, 1000, 0);
            if (i == 3) s0 = st;
        end
        idle(4);
        chk("t1_count", 32'(q16.size()), 2);
        chk("t1_d0", 32'(q16[0].d), 4000);
        chk("t1_clip0", 32'(q16[0].cl), 0);
        chk("t1_latency", 32'(q16[0].c - s0), 2);
        chk("t1_d1", 32'(q16[1].d), 4000);
        chk("t1_gap", 32'(q16[1].c - q16[0].c), 4);

        // +/-500 alternating, strobe every 5th cycle, block of 10
        b16.dec_len = 8'd10;
        q16.delete();
        for (int i = 0; i < 20; i++) begin
            drv(1'b1, (i % 2 == 0) ? 500 : -500, 0);
            idle(4);
        end
        idle(2);
        chk("t2_count", 32'(q16.size()), 2);
        chk("t2_d0", 32'(q16[0].d), 5000);
        chk("t2_clip0", 32'(q16[0].cl), 0);
        chk("t2_d1", 32'(q16[1].d), 5000);
        chk("t2_gap", 32'(q16[1].c - q16[0].c), 50);

        // most-negative sample clamps and flags clip; next block clean
        b16.dec_len = 8'd4;
        q16.delete();
        drv(1'b1, -32768, 0);
        for (int i = 0; i < 7; i++) drv(1'b1, 0, 0);
        idle(3);
        chk("t3_count", 32'(q16.size()), 2);
        chk("t3_d0", 32'(q16[0].d), 32767);
        chk("t3_clip0", 32'(q16[0].cl), 1);
        chk("t3_d1", 32'(q16[1].d), 0);
        chk("t3_clip1", 32'(q16[1].cl), 0);
        chk("t3_hold_clip", 32'(b16.clip), 0);

        // 255 full-scale samples: DW=16 exact, DW=18 saturates
        b16.dec_len = 8'd255;
        b18.dec_len = 8'd255;
        b18.en      = 1'b1;
        q16.delete();
        q18.delete();
        for (int i = 0; i < 255; i++) drv(1'b1, 32767, 131071);
        idle(3);
        b18.en = 1'b0;
        chk("t4_count16", 32'(q16.size()), 1);
        chk("t4_d16", 32'(q16[0].d), 8355585);
        chk("t4_clip16", 32'(q16[0].cl), 1);
        chk("t4_count18", 32'(q18.size()), 1);
        chk("t4_d18_sat", 32'(q18[0].d), 16777215);
        chk("t4_clip18", 32'(q18[0].cl), 1);

        // en low for 3 cycles after 2 samples; strobes while low ignored
        b16.dec_len = 8'd4;
        q16.delete();
        drv(1'b1, 1000, 0);
        drv(1'b1, 1000, 0);
        drv(1'b1, 7777, 0);
        b16.en = 1'b0;
        drv(1'b1, 7777, 0);
        drv(1'b1, 7777, 0);
        drv(1'b1, 300, 0);
        b16.en = 1'b1;
        for (int i = 0; i < 3; i++) drv(1'b1, 300, 0);
        s0 = st;
        idle(3);
        chk("t5_count", 32'(q16.size()), 1);
        chk("t5_d0", 32'(q16[0].d), 1200);
        chk("t5_latency", 32'(q16[0].c - s0), 2);

        // dec_len 4 -> 8 after the block has latched its length
        q16.delete();
        for (int i = 0; i < 12; i++) begin
            drv(1'b1, 10, 0);
            if (i == 2) b16.dec_len = 8'd8;
        end
        idle(3);
        chk("t6_count", 32'(q16.size()), 2);
        chk("t6_d0", 32'(q16[0].d), 40);
        chk("t6_d1", 32'(q16[1].d), 80);
        chk("t6_gap", 32'(q16[1].c - q16[0].c), 8);

        // reset mid-block drops the partial sum
        b16.dec_len = 8'd4;
        drv(1'b1, 999, 0);
        drv(1'b1, 999, 0);
        drv(1'b0, 0, 0);
        rst = 1'b1;
        idle(1);
        chk("t7_rst_data_out", 32'(b16.data_out), 0);
        chk("t7_rst_data_s", 32'(b16.data_s), 0);
        chk("t7_rst_clip", 32'(b16.clip), 0);
        rst = 1'b0;
        q16.delete();
        for (int i = 0; i < 4; i++) drv(1'b1, 250, 0);
        idle(3);
        chk("t7_count", 32'(q16.size()), 1);
        chk("t7_d0", 32'(q16[0].d), 1000);

        // dec_len=0 behaves as 1: one result per sample
        b16.dec_len = 8'd0;
        q16.delete();
        drv(1'b1, -5, 0);
        s0 = st;
        drv(1'b1, 7, 0);
        drv(1'b1, -32767, 0);
        drv(1'b1, 32767, 0);
        idle(3);
        chk("t8_count", 32'(q16.size()), 4);
        chk("t8_d0", 32'(q16[0].d), 5);
        chk("t8_latency", 32'(q16[0].c - s0), 2);
        chk("t8_d1", 32'(q16[1].d), 7);
        chk("t8_d2", 32'(q16[2].d), 32767);
        chk("t8_clip2", 32'(q16[2].cl), 0);
        chk("t8_d3", 32'(q16[3].d), 32767);
        chk("t8_clip3", 32'(q16[3].cl), 1);
        chk("t8_gap", 32'(q16[3].c - q16[0].c), 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
